// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default baud divider and frame-length helpers.
// UART_TX_PARITY_EN adds one even-parity bit to every frame.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // 100 MHz system clock at 115200 baud.
  localparam int UART_DEFAULT_CLKS_PER_BAUD = 868;
  localparam int UART_DEFAULT_W             = 8;

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_OVERHEAD = 3;
`else
  localparam int UART_FRAME_OVERHEAD = 2;
`endif

  function automatic int uart_frame_bits(input int w);
    return w + UART_FRAME_OVERHEAD;
  endfunction

  function automatic int uart_frame_clks(input int w, input int cpb);
    return uart_frame_bits(w) * cpb;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// FIFO read port as seen by the UART transmitter; master = FIFO side, slave = transmitter.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int W = UART_DEFAULT_W
);

  // i_fifo_data is valid combinationally whenever i_fifo_empty is low; each
  // cycle with o_fifo_rd high pops exactly one word, and o_fifo_rd is only
  // raised while i_fifo_empty is low.
  logic         i_fifo_empty;
  logic [W-1:0] i_fifo_data;
  logic         o_fifo_rd;

  modport master (
    output i_fifo_empty,
    output i_fifo_data,
    input  o_fifo_rd
  );

  modport slave (
    input  i_fifo_empty,
    input  i_fifo_data,
    output o_fifo_rd
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: o_tick marks the last clock of a bit; i_clr restarts the period.
// Shared between the UART transmitter and receiver.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = UART_DEFAULT_CLKS_PER_BAUD
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BAUD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_clr || o_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter draining a first-word-fall-through FIFO, frames back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int W             = UART_DEFAULT_W,
  parameter int CLKS_PER_BAUD = UART_DEFAULT_CLKS_PER_BAUD
) (
  input  logic        clk,
  input  logic        i_rst_n,
  uart_tx_if.slave    fifo,
  output logic        o_tx,
  output logic        o_busy,
  output logic [2:0]  o_state
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(W - 1);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_STOP   = ST_STOP;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = ST_PARITY;
`endif

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          tick;
  logic          baud_clr;
  logic          pop;

  // Gated by reset so no word is lost from the FIFO while the line is held in reset.
  assign pop = i_rst_n && !fifo.i_fifo_empty &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && tick));

  // Holding the counter clear in IDLE makes every state entry start a fresh bit period.
  assign baud_clr = (state_q == S_IDLE) || tick;

  uart_baud_gen #(
    .CLKS_PER_BAUD(CLKS_PER_BAUD)
  ) u_baud (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (baud_clr),
    .o_tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (pop) begin
      state_d = S_START;
      shift_d = fifo.i_fifo_data;
      idx_d   = '0;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo.i_fifo_data;
`endif
    end else if (tick) begin
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
        S_DATA: begin
          shift_d = shift_q >> 1;
          idx_d   = (idx_q == LAST_BIT) ? '0 : idx_q + IW'(1);
          if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_d[0];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
`endif
        S_STOP: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign fifo.o_fifo_rd = pop;
  assign o_tx           = tx_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_state        = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO model feeds the DUT, a line monitor rebuilds frames and
// compares them with frames queued at pop time. Honours UART_TX_PARITY_EN.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int W   = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = W + 3;
`else
  localparam int FB = W + 2;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       o_tx;
  logic       o_busy;
  logic [2:0] o_state;

  uart_tx_if #(.W(W)) fifo ();

  uart_tx #(
    .W             (W),
    .CLKS_PER_BAUD (CPB)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .fifo    (fifo),
    .o_tx    (o_tx),
    .o_busy  (o_busy),
    .o_state (o_state)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard
  logic [W-1:0]  fifo_q[$];
  logic [FB-1:0] exp_q[$];
  int            start_q[$];
  int            cyc          = 0;
  int            last_pop_cyc = -10;
  int            pop_cnt      = 0;
  int            busy_cnt     = 0;
  int            frames_done  = 0;
  bit            pop_pending  = 1'b0;
  bit            mon_active   = 1'b0;
  int            mon_cyc      = 0;
  logic [FB-1:0] mon_bits     = '0;
  logic [FB-1:0] mon_exp;
  logic          bit_val      = 1'b1;

  // Frame as seen on the line, index 0 = start bit, last index = stop bit.
  function automatic logic [FB-1:0] mk_frame(input logic [W-1:0] d);
    logic [FB-1:0] f;
    f        = '0;
    f[FB-1]  = 1'b1;
    for (int i = 0; i < W; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    f[W+1] = ^d;
`endif
    return f;
  endfunction

  // FIFO model + line monitor, evaluated once per cycle away from the rising edge.
  always @(negedge clk) begin
    cyc++;
    if (pop_pending) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_pending = 1'b0;
    end
    fifo.i_fifo_empty = (fifo_q.size() == 0);
    fifo.i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    if (o_busy === 1'b1) busy_cnt++;
    if (rst_n !== 1'b1) begin
      mon_active = 1'b0;
      exp_q.delete();
    end else begin
      if (!mon_active && o_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_bits   = '0;
        start_q.push_back(cyc);
        checks++;
        if (cyc != last_pop_cyc + 1) begin
          failures++;
          $display("FAIL pop_to_start start_cycle=%0d required=%0d", cyc, last_pop_cyc + 1);
        end
        checks++;
        if (o_busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_at_start got=%b required=1", o_busy);
        end
      end
      if (mon_active) begin
        if (mon_cyc % CPB == 0) begin
          bit_val = o_tx;
        end else begin
          checks++;
          if (o_tx !== bit_val) begin
            failures++;
            $display("FAIL bit_stable frame_cycle=%0d got=%b required=%b", mon_cyc, o_tx, bit_val);
          end
        end
        if (mon_cyc % CPB == CPB / 2) mon_bits[mon_cyc / CPB] = o_tx;
        mon_cyc++;
        if (mon_cyc == FB * CPB) begin
          mon_active = 1'b0;
          frames_done++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected got=%b required=none", mon_bits);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_bits !== mon_exp) begin
              failures++;
              $display("FAIL frame_bits got=%b required=%b", mon_bits, mon_exp);
            end
          end
        end
      end
      if (fifo.o_fifo_rd === 1'b1) begin
        checks++;
        if (fifo_q.size() == 0) begin
          failures++;
          $display("FAIL pop_when_empty got=1 required=0");
        end else begin
          exp_q.push_back(mk_frame(fifo_q[0]));
          pop_pending = 1'b1;
        end
        pop_cnt++;
        last_pop_cyc = cyc;
      end
    end
  end

  // driver: waits until the FIFO, DUT and monitor are all idle
  task automatic wait_done(output bit timed_out);
    int n;
    n         = 0;
    timed_out = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      n++;
      if (n > 2 && fifo_q.size() == 0 && !pop_pending && o_busy === 1'b0 && !mon_active) break;
      if (n > 400) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (o_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b required=1", o_tx); end
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", o_busy); end
    checks++;
    if (fifo.o_fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b required=0", fifo.o_fifo_rd); end
    checks++;
    if (o_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d required=%0d", o_state, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_empty();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      checks++;
      if (o_tx !== 1'b1) begin failures++; $display("FAIL idle_tx cycle=%0d got=%b required=1", i, o_tx); end
      checks++;
      if (fifo.o_fifo_rd !== 1'b0) begin failures++; $display("FAIL idle_rd cycle=%0d got=%b required=0", i, fifo.o_fifo_rd); end
      checks++;
      if (o_busy !== 1'b0) begin failures++; $display("FAIL idle_busy cycle=%0d got=%b required=0", i, o_busy); end
    end
  endtask

  task automatic test_single_byte(input logic [W-1:0] b, input string name);
    bit to;
    int f0;
    @(negedge clk);
    busy_cnt = 0;
    pop_cnt  = 0;
    f0       = frames_done;
    fifo_q.push_back(b);
    wait_done(to);
    checks++;
    if (to) begin failures++; $display("FAIL %s_timeout got=busy required=idle", name); end
    checks++;
    if (busy_cnt != FB * CPB) begin failures++; $display("FAIL %s_busy_cycles got=%0d required=%0d", name, busy_cnt, FB * CPB); end
    checks++;
    if (pop_cnt != 1) begin failures++; $display("FAIL %s_pops got=%0d required=1", name, pop_cnt); end
    checks++;
    if (frames_done - f0 != 1) begin failures++; $display("FAIL %s_frames got=%0d required=1", name, frames_done - f0); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL %s_pending got=%0d required=0", name, exp_q.size()); end
    checks++;
    if (o_tx !== 1'b1) begin failures++; $display("FAIL %s_idle_tx got=%b required=1", name, o_tx); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int f0;
    @(negedge clk);
    busy_cnt = 0;
    pop_cnt  = 0;
    f0       = frames_done;
    start_q.delete();
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    wait_done(to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_timeout got=busy required=idle"); end
    checks++;
    if (busy_cnt != 2 * FB * CPB) begin failures++; $display("FAIL b2b_busy_cycles got=%0d required=%0d", busy_cnt, 2 * FB * CPB); end
    checks++;
    if (pop_cnt != 2) begin failures++; $display("FAIL b2b_pops got=%0d required=2", pop_cnt); end
    checks++;
    if (frames_done - f0 != 2) begin failures++; $display("FAIL b2b_frames got=%0d required=2", frames_done - f0); end
    checks++;
    if (start_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_starts got=%0d required=2", start_q.size());
    end else if (start_q[1] - start_q[0] != FB * CPB) begin
      failures++;
      $display("FAIL b2b_gap got=%0d required=%0d", start_q[1] - start_q[0], FB * CPB);
    end
  endtask

  task automatic test_mid_frame_reset();
    bit to;
    int n;
    int f0;
    @(negedge clk);
    pop_cnt = 0;
    fifo_q.push_back(8'hA5);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (fifo.o_fifo_rd !== 1'b1 && n < 50);
    checks++;
    if (n >= 50) begin failures++; $display("FAIL mfr_pop_timeout got=no_pop required=pop"); end
    // Pop cycle p: start bit p+1..p+4, data bits 0..2 at p+5, p+9, p+13.
    repeat (13) @(negedge clk);
    #2;
    checks++;
    if (o_state !== ST_DATA) begin failures++; $display("FAIL mfr_in_data got=%0d required=%0d", o_state, ST_DATA); end
    @(negedge clk);
    fifo_q.push_back(8'h3C);
    rst_n = 1'b0;
    f0    = frames_done;
    #2;
    checks++;
    if (fifo.o_fifo_rd !== 1'b0) begin failures++; $display("FAIL mfr_rd_assert got=%b required=0", fifo.o_fifo_rd); end
    @(posedge clk);
    #1;
    checks++;
    if (o_tx !== 1'b1) begin failures++; $display("FAIL mfr_tx got=%b required=1", o_tx); end
    checks++;
    if (o_state !== ST_IDLE) begin failures++; $display("FAIL mfr_state got=%0d required=%0d", o_state, ST_IDLE); end
    @(negedge clk);
    #2;
    checks++;
    if (fifo.o_fifo_rd !== 1'b0) begin failures++; $display("FAIL mfr_rd_in_reset got=%b required=0", fifo.o_fifo_rd); end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checks++;
    if (fifo.o_fifo_rd !== 1'b1) begin failures++; $display("FAIL mfr_pop_after_release got=%b required=1", fifo.o_fifo_rd); end
    wait_done(to);
    checks++;
    if (to) begin failures++; $display("FAIL mfr_timeout got=busy required=idle"); end
    checks++;
    if (frames_done - f0 != 1) begin failures++; $display("FAIL mfr_frames got=%0d required=1", frames_done - f0); end
    checks++;
    if (pop_cnt != 2) begin failures++; $display("FAIL mfr_pops got=%0d required=2", pop_cnt); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL mfr_pending got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_single_byte(8'h55, "single_55");
    test_back_to_back();
    test_single_byte(8'h80, "msb_80");
    test_mid_frame_reset();
    test_single_byte(8'h07, "byte_07");
    test_single_byte(8'($urandom_range(0, 255)), "random");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
